// File: rtl/ontransit_pkg.sv
// Shared types and defaults for the do/g/s requester.
// State encodings, default timing constants, grant counter width.
package ontransit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int HOLD_MAX_DEF = 15;
  localparam int GAP_DEF      = 2;
  localparam int GRANT_W      = 8;

  function automatic logic [GRANT_W-1:0] sat_inc(
    input logic [GRANT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ontransit_cnt.sv
// Up counter with clear and terminal compare against a runtime limit.
// Shared between the grant wait and the release gap.
module ontransit_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == limit);

endmodule

// File: rtl/ontransit_req.sv
// Requester FSM driving do_req into the grant side, consuming g/s pulses.
// ONTRANSIT_REQ_RETRY_EN: first grant timeout of a job silently retries once.
module ontransit_req
  import ontransit_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int GAP      = GAP_DEF,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               g,
  input  logic               s,
  output logic               do_req,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [GRANT_W-1:0] grants
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX - 1);
  // GAP=0 compares against 0, so the first release cycle already hits
  localparam logic [CNT_W-1:0] GAP_LIM =
    (GAP == 0) ? '0 : CNT_W'(GAP - 1);

  state_t state;

  logic accept;
  logic grant_ev;
  logic fin;
  logic expire;
  logic gap_end;
  logic rearm_to;
  logic rearm;
  logic to_pulse;
  logic cnt_clr;
  logic cnt_inc;
  logic cnt_hit;
  logic [CNT_W-1:0] cnt_lim;

`ifdef ONTRANSIT_REQ_RETRY_EN
  logic retry;
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    accept   = req_ready & req_valid;
    grant_ev = (state == ASSERT) & g;
    fin      = (grant_ev & s) | ((state == ACTIVE) & s);
    expire   = (state == ASSERT) & ~g & cnt_hit;
    gap_end  = (state == RELEASE) & cnt_hit;
`ifdef ONTRANSIT_REQ_RETRY_EN
    rearm_to = expire & ~retry;
    rearm    = gap_end & retry;
`else
    rearm_to = 1'b0;
    rearm    = 1'b0;
`endif
    to_pulse = expire & ~rearm_to;
    cnt_clr  = accept | grant_ev | expire | fin | gap_end;
    cnt_inc  = (state == ASSERT) | (state == RELEASE);
    cnt_lim  = (state == ASSERT) ? HOLD_LIM : GAP_LIM;
  end

  ontransit_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .limit(cnt_lim),
    .hit  (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      do_req  <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      grants  <= '0;
    end else begin
      done    <= fin;
      timeout <= to_pulse;
      if (grant_ev) begin
        grants <= sat_inc(grants);
      end
      unique case (1'b1)
        accept: begin
          state  <= ASSERT;
          do_req <= 1'b1;
        end
        grant_ev & ~s: begin
          state <= ACTIVE;
        end
        fin | expire: begin
          state  <= RELEASE;
          do_req <= 1'b0;
        end
        gap_end: begin
          state  <= rearm ? ASSERT : IDLE;
          do_req <= rearm;
        end
        default: ;
      endcase
    end
  end

`ifdef ONTRANSIT_REQ_RETRY_EN
  // set during the retry gap and retry wait; any job end clears it
  always_ff @(posedge clk) begin
    if (rst || accept || fin || to_pulse) begin
      retry <= 1'b0;
    end else if (rearm_to) begin
      retry <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ontransit_req.sv
// Directed bench for ontransit_req: nominal, timeout, g=s, reset, saturation.
// Retry scenarios are exercised when ONTRANSIT_REQ_RETRY_EN is defined.
module tb_ontransit_req;

  logic       clk = 1'b0;
  logic       rst;
  logic       rv, g, s;
  logic       rr, dq, bz, dn, to;
  logic [7:0] gr;
  logic       srv, sg, ss;
  logic       srr, sdq, sbz, sdn, sto;
  logic [7:0] sgr;

  int total = 0;
  int fails = 0;
  int hi, tp, dp, rises, wt;
  logic prev;

  always #5 clk = ~clk;

  ontransit_req #(.HOLD_MAX(15), .GAP(2), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(rr),
    .g(g), .s(s), .do_req(dq), .busy(bz), .done(dn),
    .timeout(to), .grants(gr)
  );

  ontransit_req #(.HOLD_MAX(15), .GAP(0), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .req_valid(srv), .req_ready(srr),
    .g(sg), .s(ss), .do_req(sdq), .busy(sbz), .done(sdn),
    .timeout(sto), .grants(sgr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic watch(input int n);
    hi = 0; tp = 0; dp = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (dq) hi++;
      if (dq && !prev) rises++;
      if (to) tp++;
      if (dn) dp++;
      prev = dq;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; rv = 0; g = 0; s = 0; srv = 0; sg = 0; ss = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_do", dq, 0);
    chk("rst_busy", bz, 0);
    chk("rst_ready", rr, 1);
    chk("rst_grants", gr, 0);
    chk("rst_done", dn, 0);
    chk("rst_timeout", to, 0);

    // nominal: accept c0, g c3 (held c4), s c6
    rv = 1; tick(); rv = 0;
    chk("nom_do_c1", dq, 1);
    chk("nom_ready_c1", rr, 0);
    tick(); tick();
    g = 1; tick();
    chk("nom_grants_c4", gr, 1);
    chk("nom_do_c4", dq, 1);
    tick(); g = 0;
    chk("nom_grant_repeat", gr, 1);
    tick();
    s = 1; tick(); s = 0;
    chk("nom_done_c7", dn, 1);
    chk("nom_do_c7", dq, 0);
    chk("nom_to_c7", to, 0);
    tick();
    chk("nom_done_c8", dn, 0);
    chk("nom_ready_c8", rr, 0);
    tick();
    chk("nom_ready_c9", rr, 1);

    // s without g in ASSERT is ignored
    rv = 1; tick(); rv = 0;
    s = 1; tick(); s = 0;
    chk("sng_do", dq, 1);
    chk("sng_done", dn, 0);
    g = 1; tick(); g = 0;
    chk("sng_grants", gr, 2);
    s = 1; tick(); s = 0;
    chk("sng_done2", dn, 1);
    tick(); tick();
    chk("sng_ready", rr, 1);

    // grant timeout
    rv = 1; tick(); rv = 0;
    watch(40);
`ifdef ONTRANSIT_REQ_RETRY_EN
    chk("to_do_cycles", hi, 30);
    chk("to_rises", rises, 2);
`else
    chk("to_do_cycles", hi, 15);
    chk("to_rises", rises, 1);
`endif
    chk("to_pulses", tp, 1);
    chk("to_done", dp, 0);
    chk("to_grants", gr, 2);
    chk("to_ready", rr, 1);

    // g and s together in first ASSERT cycle
    rv = 1; tick(); rv = 0;
    g = 1; s = 1; tick(); g = 0; s = 0;
    chk("gs_done", dn, 1);
    chk("gs_do", dq, 0);
    chk("gs_grants", gr, 3);
    chk("gs_busy", bz, 1);
    tick();
    chk("gs_no_active", dq, 0);
    tick();
    chk("gs_ready", rr, 1);

`ifdef ONTRANSIT_REQ_RETRY_EN
    // grant arrives on the retry attempt
    rv = 1; tick(); rv = 0;
    wt = 0;
    while (dq && wt < 40) begin tick(); wt++; end
    chk("rg_first_drop", dq, 0);
    wt = 0;
    while (!dq && wt < 10) begin tick(); wt++; end
    chk("rg_reassert", dq, 1);
    chk("rg_no_ready", rr, 0);
    g = 1; s = 1; tick(); g = 0; s = 0;
    chk("rg_done", dn, 1);
    chk("rg_timeout", to, 0);
    chk("rg_grants", gr, 4);
    tick(); tick();
    chk("rg_ready", rr, 1);
`endif

    // reset mid-ACTIVE
    rv = 1; tick(); rv = 0;
    g = 1; tick(); g = 0;
    chk("ra_do_pre", dq, 1);
    rst = 1; tick(); rst = 0;
    chk("ra_do", dq, 0);
    chk("ra_busy", bz, 0);
    chk("ra_grants", gr, 0);
    chk("ra_ready", rr, 1);

    // saturation with GAP=0
    for (int j = 0; j < 260; j++) begin
      srv = 1; tick(); srv = 0;
      sg = 1; tick(); sg = 0;
      ss = 1; tick(); ss = 0;
      if (j == 0) chk("sat_done0", sdn, 1);
      tick();
      if (j == 0) chk("sat_gap0_ready", srr, 1);
      if (j == 253) chk("sat_grants254", sgr, 254);
    end
    chk("sat_grants", sgr, 255);
    chk("sat_timeout", sto, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
